// File: rtl/fetch_ctrl_if.sv
// Bundles the redirect, instruction-memory and decode-side signals of the fetch stage.
// The master view belongs to fetch_ctrl; the slave view belongs to its surroundings.
interface fetch_ctrl_if;
    logic        redirValid;
    logic        redirExc;
    logic [31:0] redirPc;

    logic        imReq;
    logic [31:0] imAddr;
    logic        imAck;
    logic [31:0] imRdata;

    logic        idValid;
    logic        idReady;
    logic [31:0] idInst;
    logic [31:0] idPc;

    modport master (
        input  redirValid, redirExc, redirPc,
        output imReq, imAddr,
        input  imAck, imRdata,
        output idValid, idInst, idPc,
        input  idReady
    );

    modport slave (
        output redirValid, redirExc, redirPc,
        input  imReq, imAddr,
        output imAck, imRdata,
        input  idValid, idInst, idPc,
        output idReady
    );
endinterface

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: issues one word request at a time, buffers the returned word toward
// decode (output register plus one skid entry) and applies EX-stage redirects.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0380,
    parameter logic [31:0] EXC_VEC  = 32'h8000_0180
) (
    input logic          clk,
    input logic          rst,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_DRAIN = 2'd2
    } state_e;

    state_e      stateQ, stateD;
    logic [31:0] pcQ, pcD;
    logic [31:0] pendPcQ, pendPcD;
    logic        idValidQ, idValidD;
    logic [31:0] idInstQ, idInstD;
    logic [31:0] idPcQ, idPcD;
    logic [31:0] skidInstQ, skidInstD;
    logic [31:0] skidPcQ, skidPcD;

    logic        reqOut;
    logic        ackHit;
    logic        slotFree;
    logic [31:0] pcPlus4;
    logic [31:0] redirTarget;

    // Request is suppressed in the reset cycle so a late ack can never be consumed.
    assign reqOut      = !rst && (stateQ != S_WAIT);
    assign ackHit      = reqOut && bus.imAck;
    assign slotFree    = !idValidQ || bus.idReady;
    assign pcPlus4     = pcQ + 32'd4;
    assign redirTarget = bus.redirExc ? EXC_VEC : bus.redirPc;

    assign bus.imReq   = reqOut;
    assign bus.imAddr  = pcQ;
    assign bus.idValid = idValidQ;
    assign bus.idInst  = idInstQ;
    assign bus.idPc    = idPcQ;

    always_comb begin
        stateD    = stateQ;
        pcD       = pcQ;
        pendPcD   = pendPcQ;
        idValidD  = idValidQ;
        idInstD   = idInstQ;
        idPcD     = idPcQ;
        skidInstD = skidInstQ;
        skidPcD   = skidPcQ;

        if (idValidQ && bus.idReady) begin
            idValidD = 1'b0;
        end

        unique case (stateQ)
            S_REQ: begin
                if (ackHit) begin
                    pcD = pcPlus4;
                    if (slotFree) begin
                        idValidD = 1'b1;
                        idInstD  = bus.imRdata;
                        idPcD    = pcQ;
                    end else begin
                        skidInstD = bus.imRdata;
                        skidPcD   = pcQ;
                        stateD    = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                // In S_WAIT the output register is always occupied, so idReady means a transfer.
                if (bus.idReady) begin
                    idValidD = 1'b1;
                    idInstD  = skidInstQ;
                    idPcD    = skidPcQ;
                    stateD   = S_REQ;
                end
            end
            S_DRAIN: begin
                if (ackHit) begin
                    pcD    = pendPcQ;
                    stateD = S_REQ;
                end
            end
            default: begin
                stateD = S_REQ;
            end
        endcase

        // A redirect squashes anything buffered; an un-acked request must still drain.
        if (bus.redirValid) begin
            idValidD = 1'b0;
            unique case (stateQ)
                S_REQ: begin
                    if (ackHit) begin
                        pcD    = redirTarget;
                        stateD = S_REQ;
                    end else begin
                        pcD     = pcQ;
                        pendPcD = redirTarget;
                        stateD  = S_DRAIN;
                    end
                end
                S_WAIT: begin
                    pcD    = redirTarget;
                    stateD = S_REQ;
                end
                S_DRAIN: begin
                    pendPcD = redirTarget;
                    if (ackHit) begin
                        pcD    = redirTarget;
                        stateD = S_REQ;
                    end else begin
                        stateD = S_DRAIN;
                    end
                end
                default: begin
                    pcD    = redirTarget;
                    stateD = S_REQ;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stateQ    <= S_REQ;
            pcQ       <= RESET_PC;
            pendPcQ   <= 32'd0;
            idValidQ  <= 1'b0;
            idInstQ   <= 32'd0;
            idPcQ     <= 32'd0;
            skidInstQ <= 32'd0;
            skidPcQ   <= 32'd0;
        end else begin
            stateQ    <= stateD;
            pcQ       <= pcD;
            pendPcQ   <= pendPcD;
            idValidQ  <= idValidD;
            idInstQ   <= idInstD;
            idPcQ     <= idPcD;
            skidInstQ <= skidInstD;
            skidPcQ   <= skidPcD;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Scoreboard bench for fetch_ctrl: memory model with ack budget/latency, directed
// redirect/backpressure sequences, and a monitor that checks every decode transfer.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fetch_ctrl_if bus();

    fetch_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;
    int ackBudget = 0;
    int ackDelay  = 0;
    int waitCnt   = 0;
    logic [31:0] expQ[$];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Memory model: returns ~address as data after ackDelay waiting cycles, ackBudget times.
    always @(posedge clk) begin
        #2;
        if (bus.imReq === 1'b1 && ackBudget > 0) begin
            if (waitCnt >= ackDelay) begin
                bus.imAck   = 1'b1;
                bus.imRdata = ~bus.imAddr;
                ackBudget   = ackBudget - 1;
                waitCnt     = 0;
            end else begin
                bus.imAck   = 1'b0;
                bus.imRdata = 32'hDEAD_BEEF;
                waitCnt     = waitCnt + 1;
            end
        end else begin
            bus.imAck   = 1'b0;
            bus.imRdata = 32'hDEAD_BEEF;
            waitCnt     = 0;
        end
    end

    // Monitor: every decode transfer must match the oldest expected pc.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.idValid === 1'b1 && bus.idReady === 1'b1) begin
            if (expQ.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL sb_unexpected: got idPc %h, expected no transfer", bus.idPc);
            end else begin
                automatic logic [31:0] expPc = expQ.pop_front();
                checkOutput("sb_idPc", bus.idPc, expPc);
                checkOutput("sb_idInst", bus.idInst, ~expPc);
            end
        end
    end

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rv, input logic rexc, input logic [31:0] rpc,
                                 input logic rdy, input int budget, input int delay);
        bus.redirValid = rv;
        bus.redirExc   = rexc;
        bus.redirPc    = rpc;
        bus.idReady    = rdy;
        ackBudget      = budget;
        ackDelay       = delay;
    endtask

    task automatic resetDut();
        nextCycle();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 0, 0);
        nextCycle();
        @(negedge clk);
        checkOutput("rst_cycle_imReq", {31'd0, bus.imReq}, 32'd0);
        checkOutput("rst_cycle_idValid", {31'd0, bus.idValid}, 32'd0);
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic waitIdle();
        int n = 0;
        while ((ackBudget != 0 || expQ.size() != 0) && n < 60) begin
            nextCycle();
            n++;
        end
        checkOutput("idle_queue", expQ.size(), 32'd0);
        checkOutput("idle_budget", ackBudget, 32'd0);
        nextCycle();
        nextCycle();
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 0, 0);

        // 1: reset values, then zero-wait streaming
        resetDut();
        @(negedge clk);
        checkOutput("reset_imReq", {31'd0, bus.imReq}, 32'd1);
        checkOutput("reset_imAddr", bus.imAddr, 32'hBFC0_0380);
        checkOutput("reset_idValid", {31'd0, bus.idValid}, 32'd0);
        checkOutput("reset_idPc", bus.idPc, 32'd0);
        checkOutput("reset_idInst", bus.idInst, 32'd0);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 4, 0);
        expQ.push_back(32'hBFC0_0380);
        expQ.push_back(32'hBFC0_0384);
        expQ.push_back(32'hBFC0_0388);
        expQ.push_back(32'hBFC0_038C);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("stream_imAddr", bus.imAddr, 32'hBFC0_0380 + 32'(4 * i));
            nextCycle();
        end
        waitIdle();

        // 2: three wait cycles, address held, single output pulse
        resetDut();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, 1, 3);
        expQ.push_back(32'hBFC0_0380);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("wait_imAddr", bus.imAddr, 32'hBFC0_0380);
            checkOutput("wait_imAck", {31'd0, bus.imAck}, 32'd0);
            nextCycle();
        end
        @(negedge clk);
        checkOutput("wait_ackCycle", {31'd0, bus.imAck}, 32'd1);
        @(negedge clk);
        checkOutput("wait_idValid", {31'd0, bus.idValid}, 32'd1);
        checkOutput("wait_idPc", bus.idPc, 32'hBFC0_0380);
        @(negedge clk);
        checkOutput("wait_pulseEnd", {31'd0, bus.idValid}, 32'd0);
        waitIdle();

        // 3: backpressure fills the skid entry, nothing lost on release
        resetDut();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 2, 0);
        expQ.push_back(32'hBFC0_0380);
        expQ.push_back(32'hBFC0_0384);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("bp_imReq_off", {31'd0, bus.imReq}, 32'd0);
        @(negedge clk);
        checkOutput("bp_imReq_off2", {31'd0, bus.imReq}, 32'd0);
        checkOutput("bp_idPc_held", bus.idPc, 32'hBFC0_0380);
        nextCycle();
        bus.idReady = 1'b1;
        @(negedge clk);
        checkOutput("bp_imReq_off3", {31'd0, bus.imReq}, 32'd0);
        @(negedge clk);
        checkOutput("bp_imReq_on", {31'd0, bus.imReq}, 32'd1);
        checkOutput("bp_imAddr", bus.imAddr, 32'hBFC0_0388);
        checkOutput("bp_idPc_skid", bus.idPc, 32'hBFC0_0384);
        waitIdle();

        // 4: redirect while a request is outstanding drains the wrong-path word
        resetDut();
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h8000_1000, 1'b1, 2, 2);
        expQ.push_back(32'h8000_1000);
        @(negedge clk);
        checkOutput("drain_imAddr0", bus.imAddr, 32'hBFC0_0380);
        nextCycle();
        bus.redirValid = 1'b0;
        @(negedge clk);
        checkOutput("drain_imReq", {31'd0, bus.imReq}, 32'd1);
        checkOutput("drain_imAddr1", bus.imAddr, 32'hBFC0_0380);
        @(negedge clk);
        checkOutput("drain_ack", {31'd0, bus.imAck}, 32'd1);
        @(negedge clk);
        checkOutput("drain_newAddr", bus.imAddr, 32'h8000_1000);
        checkOutput("drain_idValid", {31'd0, bus.idValid}, 32'd0);
        waitIdle();

        // 5: exception redirect coincident with ack
        resetDut();
        nextCycle();
        applyStimulus(1'b1, 1'b1, 32'h1234_5678, 1'b1, 2, 0);
        expQ.push_back(32'h8000_0180);
        @(negedge clk);
        checkOutput("exc_ack", {31'd0, bus.imAck}, 32'd1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b1, ackBudget, 0);
        @(negedge clk);
        checkOutput("exc_idValid", {31'd0, bus.idValid}, 32'd0);
        checkOutput("exc_imAddr", bus.imAddr, 32'h8000_0180);
        waitIdle();

        // 6a: pc wraps from FFFFFFFC to 0
        resetDut();
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFC, 1'b1, 3, 0);
        expQ.push_back(32'hFFFF_FFFC);
        expQ.push_back(32'h0000_0000);
        nextCycle();
        bus.redirValid = 1'b0;
        @(negedge clk);
        checkOutput("wrap_imAddr0", bus.imAddr, 32'hFFFF_FFFC);
        @(negedge clk);
        checkOutput("wrap_imAddr1", bus.imAddr, 32'h0000_0000);
        waitIdle();

        // 6b: reset while waiting on decode
        resetDut();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 2, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        checkOutput("rstwait_imReq", {31'd0, bus.imReq}, 32'd0);
        nextCycle();
        rst = 1'b1;
        @(negedge clk);
        checkOutput("rstwait_rstReq", {31'd0, bus.imReq}, 32'd0);
        nextCycle();
        rst = 1'b0;
        bus.idReady = 1'b1;
        @(negedge clk);
        checkOutput("rstwait_imReq_on", {31'd0, bus.imReq}, 32'd1);
        checkOutput("rstwait_imAddr", bus.imAddr, 32'hBFC0_0380);
        checkOutput("rstwait_idValid", {31'd0, bus.idValid}, 32'd0);
        waitIdle();

        // 7: redirect while the skid entry is full discards both buffered words
        resetDut();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 32'd0, 1'b0, 2, 0);
        @(negedge clk);
        @(negedge clk);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 32'h0000_2000, 1'b0, 1, 0);
        expQ.push_back(32'h0000_2000);
        @(negedge clk);
        checkOutput("skidredir_imReq", {31'd0, bus.imReq}, 32'd0);
        nextCycle();
        bus.redirValid = 1'b0;
        bus.idReady    = 1'b1;
        @(negedge clk);
        checkOutput("skidredir_idValid", {31'd0, bus.idValid}, 32'd0);
        checkOutput("skidredir_imAddr", bus.imAddr, 32'h0000_2000);
        waitIdle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
